// File: rtl/prio_encoder_q_if.sv
// Request/grant bundle for prio_encoder_q.
//   req   : request lines, bit i = request i (master -> slave)
//   ack   : consumer accepts the presented index (master -> slave)
//   a     : encoded index of the presented request (slave -> master)
//   valid : a holds a request awaiting ack (slave -> master)
//   pend  : pending-request register (slave -> master)
//   lost  : one-cycle pulse, request hit an already-pending line (slave -> master)
interface prio_encoder_q_if #(
  parameter int N = 4,
  parameter int W = 2
);
  logic [N-1:0] req;
  logic         ack;
  logic [W-1:0] a;
  logic         valid;
  logic [N-1:0] pend;
  logic         lost;

  modport master (output req, ack, input a, valid, pend, lost);
  modport slave  (input req, ack, output a, valid, pend, lost);
endinterface

// File: rtl/prio_encoder_q.sv
// Pending-request priority encoder.
// Request lines are accumulated into a pending register; the lowest-indexed
// pending request is presented as a binary index with a valid/ack handshake
// and cleared from the pending register once acknowledged.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : prio_encoder_q_if slave (req, ack in; a, valid, pend, lost out)
module prio_encoder_q #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic               clk,
  input  logic               rst,
  prio_encoder_q_if.slave    bus
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] pend_q,  pend_d;
  logic [W-1:0] a_q,     a_d;
  logic         lost_q,  lost_d;
  logic [N-1:0] served;

  // Index of the lowest set bit; bit 0 has the highest priority.
  function automatic logic [W-1:0] lowest_index(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = W'(i);
    end
    return idx;
  endfunction

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    served  = '0;

    if (state_q == PRESENT && bus.ack) begin
      served = {{(N-1){1'b0}}, 1'b1} << a_q;
    end

    // A request on the line being served this cycle is a fresh request,
    // so it survives the clear and does not count as lost.
    pend_d = (pend_q & ~served) | bus.req;
    lost_d = |(bus.req & pend_q & ~served);

    case (state_q)
      IDLE: begin
        // Grant decision uses the registered pend, not pend_d.
        if (|pend_q) begin
          a_d     = lowest_index(pend_q);
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        // a is frozen while presenting, even if higher-priority work arrives.
        if (bus.ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      a_q     <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      a_q     <= a_d;
      lost_q  <= lost_d;
    end
  end

  assign bus.a     = a_q;
  assign bus.valid = (state_q == PRESENT);
  assign bus.pend  = pend_q;
  assign bus.lost  = lost_q;

endmodule

// File: tb/tb_prio_encoder_q.sv
module tb_prio_encoder_q;
  localparam int N = 4;
  localparam int W = 2;

  logic clk = 1'b0;
  logic rst;

  prio_encoder_q_if #(.N(N), .W(W)) bus ();

  prio_encoder_q #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: pending set kept as an integer bitmask.
  int m_pend  = 0;
  int m_a     = 0;
  bit m_valid = 1'b0;
  bit m_lost  = 1'b0;
  int grants[$];

  function automatic int lowest(input int p);
    int low;
    int idx;
    low = p & -p;
    idx = 0;
    while (low > 1) begin
      low = low / 2;
      idx++;
    end
    return idx;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_pend"},  32'(bus.pend),  32'(m_pend));
    chk({tag, "_valid"}, 32'(bus.valid), 32'(m_valid));
    chk({tag, "_lost"},  32'(bus.lost),  32'(m_lost));
    if (m_valid) chk({tag, "_a"}, 32'(bus.a), 32'(m_a));
  endtask

  task automatic model_reset();
    m_pend = 0; m_a = 0; m_valid = 1'b0; m_lost = 1'b0;
  endtask

  task automatic set_in(input int r, input bit k);
    bus.req = N'(r);
    bus.ack = k;
  endtask

  // One clock edge: advance the model with the inputs seen at the edge,
  // then compare the DUT just after the edge.
  task automatic tick(input string tag);
    int r;
    int served;
    bit k;
    @(posedge clk);
    r = int'(bus.req);
    k = bus.ack;
    served = (m_valid && k) ? (1 << m_a) : 0;
    m_lost = ((r & m_pend & ~served) != 0);
    if (!m_valid) begin
      if (m_pend != 0) begin
        m_a     = lowest(m_pend);
        m_valid = 1'b1;
      end
    end else if (k) begin
      m_valid = 1'b0;
    end
    m_pend = (m_pend & ~served) | r;
    #1;
    check_model(tag);
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 1'b0);
    #12;
    chk("rst_pend",  32'(bus.pend),  32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_a",     32'(bus.a),     32'd0);
    chk("rst_lost",  32'(bus.lost),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: asynchronous reset while presenting with pend=1010
    set_in('b1010, 1'b0); tick("t1_e1");
    set_in(0, 1'b0);      tick("t1_e2");
    chk("t1_pre_valid", 32'(bus.valid), 32'd1);
    chk("t1_pre_pend",  32'(bus.pend),  32'b1010);
    #2;
    rst = 1'b1;
    #1;
    chk("t1_async_pend",  32'(bus.pend),  32'd0);
    chk("t1_async_valid", 32'(bus.valid), 32'd0);
    chk("t1_async_a",     32'(bus.a),     32'd0);
    chk("t1_async_lost",  32'(bus.lost),  32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // 2: single request latency
    set_in('b0100, 1'b0); tick("t2_e1");
    chk("t2_e1_valid", 32'(bus.valid), 32'd0);
    set_in(0, 1'b0);      tick("t2_e2");
    chk("t2_e2_a", 32'(bus.a), 32'd2);
    set_in(0, 1'b1);      tick("t2_e3");
    chk("t2_e3_pend", 32'(bus.pend), 32'd0);
    set_in(0, 1'b0);

    // 3: two requests, one idle cycle between grants
    set_in('b1010, 1'b0); tick("t3_e1");
    set_in(0, 1'b0);      tick("t3_g1");
    chk("t3_g1_a", 32'(bus.a), 32'd1);
    set_in(0, 1'b1);      tick("t3_ack1");
    set_in(0, 1'b0);      tick("t3_g2");
    chk("t3_g2_a", 32'(bus.a), 32'd3);
    set_in(0, 1'b1);      tick("t3_ack2");
    chk("t3_end_pend", 32'(bus.pend), 32'd0);
    set_in(0, 1'b0);

    // 4: presented index holds against a higher-priority arrival
    set_in('b1000, 1'b0); tick("t4_e1");
    set_in(0, 1'b0);      tick("t4_g");
    set_in('b0001, 1'b0); tick("t4_hold");
    chk("t4_hold_a",    32'(bus.a),    32'd3);
    chk("t4_hold_pend", 32'(bus.pend), 32'b1001);
    set_in(0, 1'b1);      tick("t4_ack");
    set_in(0, 1'b0);      tick("t4_g2");
    chk("t4_g2_a", 32'(bus.a), 32'd0);
    set_in(0, 1'b1);      tick("t4_ack2");
    set_in(0, 1'b0);

    // 5a: re-request in the ack cycle is a new request
    set_in('b0100, 1'b0); tick("t5_e1");
    set_in(0, 1'b0);      tick("t5_g");
    set_in('b0100, 1'b1); tick("t5_reack");
    chk("t5_reack_pend", 32'(bus.pend), 32'b0100);
    chk("t5_reack_lost", 32'(bus.lost), 32'd0);
    set_in(0, 1'b0);      tick("t5_g2");
    chk("t5_g2_a", 32'(bus.a), 32'd2);
    set_in(0, 1'b1);      tick("t5_ack2");
    // 5b: request on an unserved pending line is lost
    set_in('b0010, 1'b0); tick("t5_l1");
    set_in(0, 1'b0);      tick("t5_l2");
    set_in('b0010, 1'b0); tick("t5_lost");
    chk("t5_lost_pulse", 32'(bus.lost), 32'd1);
    chk("t5_lost_pend",  32'(bus.pend), 32'b0010);
    set_in(0, 1'b0);      tick("t5_lost_end");
    chk("t5_lost_clear", 32'(bus.lost), 32'd0);
    set_in(0, 1'b1);      tick("t5_ack3");
    set_in(0, 1'b0);      tick("t5_idle");

    // 6: ack while idle is ignored, then all four lines drained in order
    set_in(0, 1'b1);      tick("t6_idle1");
    tick("t6_idle2");
    set_in('b1111, 1'b1); tick("t6_load");
    set_in(0, 1'b1);
    grants.delete();
    for (int i = 0; i < 8; i++) begin
      tick("t6_drain");
      if (bus.valid) grants.push_back(int'(bus.a));
    end
    chk("t6_grant_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < grants.size()) chk("t6_grant_order", 32'(grants[i]), 32'(i));
    end
    chk("t6_final_pend", 32'(bus.pend), 32'd0);
    set_in(0, 1'b0);

    // Randomized traffic against the model, with one asynchronous reset.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (1 << N) - 1)) : 0;
      set_in(r, 1'($urandom_range(0, 1)));
      tick("rnd");
      if (i == 200) begin
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_model("rnd_rst");
        @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
